// File: rtl/bsg_ss_downstream_in.sv
`default_nettype none
// ============================================================================
// Module   : bsg_ss_downstream_in
// Purpose  : Receive endpoint of the BSG source-synchronous link. Pairs two
//            32-bit link cycles into 64-bit words, buffers them in a
//            credit-sized FWFT FIFO, and returns credits on a toggling token.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_ss_downstream_in #(
  parameter  int ELS         = 16,
  parameter  int TOKEN_RATIO = 4,
  localparam int LG_ELS      = $clog2(ELS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ch0_valid_i,
  input  logic [15:0]       ch0_data_i,
  input  logic              ch1_valid_i,
  input  logic [15:0]       ch1_data_i,
  output logic              valid_o,
  output logic [63:0]       data_o,
  input  logic              yumi_i,
  output logic              token_o,
  output logic [LG_ELS:0]   count_o,
  output logic              frame_err_o,
  output logic              overflow_err_o
);

  localparam logic [LG_ELS:0] FULL_COUNT = (LG_ELS+1)'(ELS);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } asm_state_e;

  asm_state_e         state_q, state_d;
  logic [31:0]        lo_q, lo_d;
  logic [LG_ELS-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LG_ELS-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LG_ELS:0]    count_q, count_d;
  logic               token_q, token_d;
  logic               frame_err_q, frame_err_d;
  logic               overflow_err_q, overflow_err_d;
  logic [63:0]        mem_q [ELS];

  logic               both_v;
  logic               one_v;
  logic [31:0]        cw;
  logic               push_req;
  logic               push_ok;
  logic               pop;
  logic               frame_set;
  logic               tick;
  logic [63:0]        push_word;

  assign both_v    = ch0_valid_i & ch1_valid_i;
  assign one_v     = ch0_valid_i ^ ch1_valid_i;
  assign cw        = {ch1_data_i, ch0_data_i};
  assign push_word = {cw, lo_q};

  // Only a non-empty FIFO can be popped; yumi on empty is ignored.
  assign pop     = yumi_i & (count_q != '0);
  // A simultaneous pop frees the slot the push needs, even when full.
  assign push_ok = push_req & ((count_q < FULL_COUNT) | pop);

  // Assembler next state: pairs valid cycles, flags mismatches and gaps.
  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
    if (one_v) begin
      frame_set = 1'b1;
      state_d   = ST_EMPTY;
    end else if (both_v) begin
      if (state_q == ST_EMPTY) begin
        lo_d    = cw;
        state_d = ST_HALF;
      end else begin
        push_req = 1'b1;
        state_d  = ST_EMPTY;
      end
    end else if (state_q == ST_HALF) begin
      frame_set = 1'b1;
      state_d   = ST_EMPTY;
    end
  end

  // FIFO pointer/occupancy bookkeeping, sticky errors and token line.
  always_comb begin
    wr_ptr_d       = push_ok ? wr_ptr_q + LG_ELS'(1) : wr_ptr_q;
    rd_ptr_d       = pop     ? rd_ptr_q + LG_ELS'(1) : rd_ptr_q;
    count_d        = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + (LG_ELS+1)'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - (LG_ELS+1)'(1);
    end
    frame_err_d    = frame_err_q | frame_set;
    overflow_err_d = overflow_err_q | (push_req & ~push_ok);
    token_d        = token_q ^ tick;
  end

  generate
    if (TOKEN_RATIO > 1) begin : g_div
      localparam int DIV_W = $clog2(TOKEN_RATIO);
      localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TOKEN_RATIO - 1);
      logic [DIV_W-1:0] div_q, div_d;

      assign tick = pop & (div_q == DIV_LAST);

      // Divider advances per pop and clears when it emits a token toggle.
      always_comb begin
        div_d = div_q;
        if (pop) begin
          div_d = tick ? '0 : div_q + DIV_W'(1);
        end
      end

      // Divider register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          div_q <= '0;
        end else begin
          div_q <= div_d;
        end
      end
    end else begin : g_nodiv
      assign tick = pop;
    end
  endgenerate

  // Control state: assembler, pointers, count, token and error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_EMPTY;
      lo_q           <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      token_q        <= 1'b0;
      frame_err_q    <= 1'b0;
      overflow_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      lo_q           <= lo_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      token_q        <= token_d;
      frame_err_q    <= frame_err_d;
      overflow_err_q <= overflow_err_d;
    end
  end

  // Storage array; contents are don't-care until count marks them live.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

  assign valid_o        = (count_q != '0);
  assign data_o         = valid_o ? mem_q[rd_ptr_q] : 64'd0;
  assign count_o        = count_q;
  assign token_o        = token_q;
  assign frame_err_o    = frame_err_q;
  assign overflow_err_o = overflow_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bsg_ss_downstream_in.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_ss_downstream_in
// Purpose  : Scoreboard bench for bsg_ss_downstream_in: directed scenarios
//            followed by randomized link traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_ss_downstream_in;

  localparam int ELS = 16;
  localparam int TR  = 4;
  localparam int LG  = $clog2(ELS);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ch0_valid_i = 1'b0;
  logic [15:0]   ch0_data_i  = '0;
  logic          ch1_valid_i = 1'b0;
  logic [15:0]   ch1_data_i  = '0;
  logic          yumi_i      = 1'b0;
  logic          valid_o;
  logic [63:0]   data_o;
  logic          token_o;
  logic [LG:0]   count_o;
  logic          frame_err_o;
  logic          overflow_err_o;

  bsg_ss_downstream_in #(.ELS(ELS), .TOKEN_RATIO(TR)) dut (
    .clk            (clk),
    .rst            (rst),
    .ch0_valid_i    (ch0_valid_i),
    .ch0_data_i     (ch0_data_i),
    .ch1_valid_i    (ch1_valid_i),
    .ch1_data_i     (ch1_data_i),
    .valid_o        (valid_o),
    .data_o         (data_o),
    .yumi_i         (yumi_i),
    .token_o        (token_o),
    .count_o        (count_o),
    .frame_err_o    (frame_err_o),
    .overflow_err_o (overflow_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: word queue, pop total, sticky flags, half-word tracker.
  logic [63:0] exp_q [$];
  int          pops = 0;
  bit          m_ferr = 0, m_oerr = 0;
  bit          have_half = 0;
  logic [31:0] m_lo = '0;
  bit          mon_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One link cycle: drive inputs, predict the edge outcome, commit it after the edge.
  task automatic step(input bit v0, input bit v1, input logic [15:0] d0,
                      input logic [15:0] d1, input bit y);
    logic [31:0] cw;
    bit          p_push, p_ferr, p_oerr;
    logic [63:0] p_word;
    cw = {d1, d0};
    p_push = 0; p_ferr = 0; p_oerr = 0; p_word = '0;
    ch0_valid_i = v0; ch1_valid_i = v1;
    ch0_data_i  = d0; ch1_data_i  = d1;
    yumi_i      = y;
    if (v0 && v1) begin
      if (!have_half) begin
        m_lo = cw;
        have_half = 1;
      end else begin
        have_half = 0;
        if (exp_q.size() < ELS || (y && exp_q.size() > 0)) begin
          p_push = 1;
          p_word = {cw, m_lo};
        end else begin
          p_oerr = 1;
        end
      end
    end else if (v0 != v1) begin
      p_ferr = 1;
      have_half = 0;
    end else if (have_half) begin
      p_ferr = 1;
      have_half = 0;
    end
    @(posedge clk);
    #1;
    if (p_push) exp_q.push_back(p_word);
    if (p_ferr) m_ferr = 1;
    if (p_oerr) m_oerr = 1;
  endtask

  task automatic send_word(input logic [63:0] w, input bit y2);
    step(1, 1, w[15:0], w[31:16], 0);
    step(1, 1, w[47:32], w[63:48], y2);
  endtask

  task automatic idle(input bit y);
    step(0, 0, 16'h0, 16'h0, y);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    #2;
    ch0_valid_i = 0; ch1_valid_i = 0; yumi_i = 0;
    rst = 1'b1;
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_token", token_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_ferr", frame_err_o, 0);
    chk("rst_oerr", overflow_err_o, 0);
    exp_q.delete();
    pops = 0; m_ferr = 0; m_oerr = 0; have_half = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: compares status every cycle and pops/compares on each dequeue.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("count", count_o, exp_q.size());
      chk("valid", valid_o, exp_q.size() != 0);
      chk("token", token_o, (pops / TR) % 2);
      chk("frame_err", frame_err_o, m_ferr);
      chk("overflow_err", overflow_err_o, m_oerr);
      if (yumi_i && exp_q.size() > 0) begin
        chk("data", data_o, exp_q.pop_front());
        pops++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] w;
    int r;
    int ydiv;
    bit y;
    mon_en = 1;
    do_reset();

    // Basic word assembly.
    send_word(64'hFEDC_BA98_7654_3210, 0);
    chk("tp1_data", data_o, 64'hFEDC_BA98_7654_3210);
    chk("tp1_valid", valid_o, 1);
    chk("tp1_count", count_o, 1);
    idle(1);
    chk("tp2_count", count_o, 0);
    // Seven more word/pop pairs: token toggles at the 4th and 8th pop.
    for (int i = 1; i < 8; i++) begin
      send_word({$urandom, $urandom}, 0);
      idle(1);
      if (i == 3) chk("tp2_token4", token_o, 1);
      if (i == 7) chk("tp2_token8", token_o, 0);
    end

    // Overflow with no pop.
    do_reset();
    for (int i = 0; i < ELS; i++) send_word({32'hA000_0000 + i, 32'h5000_0000 + i}, 0);
    send_word(64'hDEAD_BEEF_DEAD_BEEF, 0);
    chk("ovf_count", count_o, ELS);
    chk("ovf_err", overflow_err_o, 1);
    chk("ovf_head", data_o, {32'hA000_0000, 32'h5000_0000});
    for (int i = 0; i < ELS; i++) idle(1);

    // Full with a simultaneous pop: push accepted.
    do_reset();
    for (int i = 0; i < ELS; i++) send_word({$urandom, $urandom}, 0);
    send_word(64'h1111_2222_3333_4444, 1);
    chk("fullpop_count", count_o, ELS);
    chk("fullpop_err", overflow_err_o, 0);
    for (int i = 0; i < ELS; i++) idle(1);

    // Framing gap in HALF.
    do_reset();
    step(1, 1, 16'h1234, 16'h5678, 0);
    idle(0);
    chk("gap_ferr", frame_err_o, 1);
    chk("gap_count", count_o, 0);
    send_word(64'h0123_4567_89AB_CDEF, 0);
    chk("gap_next", data_o, 64'h0123_4567_89AB_CDEF);
    idle(1);

    // Channel mismatch in HALF.
    do_reset();
    step(1, 1, 16'h1234, 16'h5678, 0);
    step(1, 0, 16'h9999, 16'h9999, 0);
    chk("mis_ferr", frame_err_o, 1);
    send_word(64'hCAFE_F00D_1357_2468, 0);
    chk("mis_next", data_o, 64'hCAFE_F00D_1357_2468);
    chk("mis_count", count_o, 1);
    idle(1);

    // Reset mid-word with buffered data.
    do_reset();
    for (int i = 0; i < 3; i++) send_word({$urandom, $urandom}, 0);
    idle(1);
    idle(1);
    step(1, 1, 16'hAAAA, 16'hBBBB, 0);
    do_reset();
    send_word(64'h7777_6666_5555_4444, 0);
    chk("rstmid_data", data_o, 64'h7777_6666_5555_4444);
    chk("rstmid_count", count_o, 1);
    idle(1);

    // Randomized traffic with varying consumer rates and periodic resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 600 == 599) do_reset();
      ydiv = (i / 200) % 3;
      r = int'($urandom % 16);
      case (ydiv)
        0:       y = ($urandom % 2) == 0;
        1:       y = ($urandom % 8) == 0;
        default: y = ($urandom % 8) != 0;
      endcase
      case (r)
        0:       step(1, 0, 16'($urandom), 16'($urandom), y);
        1:       step(0, 1, 16'($urandom), 16'($urandom), y);
        2:       step(0, 0, 16'($urandom), 16'($urandom), y);
        default: step(1, 1, 16'($urandom), 16'($urandom), y);
      endcase
    end
    idle(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
